// File: rtl/contador_ad_param.sv
// Up/down modular counter over [MIN_VAL..MAX_VAL] with edge-detected requests, load, carry/borrow.
// Optional feature macro: BCD_OUT_EN adds a registered two-digit BCD copy of count (count_bcd).
module contador_ad_param #(
  parameter int WIDTH     = 3,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 7,
  parameter int RESET_VAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_up,
  input  logic             en_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow
`ifdef BCD_OUT_EN
  ,
  output logic [7:0]       count_bcd
`endif
);

  // Range limits widened by one bit so comparisons and +/-1 never overflow WIDTH.
  localparam logic [WIDTH:0]   MIN_W   = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_W   = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MIN_N   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_N   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_N = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             carry_reg, carry_next;
  logic             borrow_reg, borrow_next;
  logic             up_q, down_q;
  logic             up_tick, dn_tick;
  logic [WIDTH:0]   count_w, load_w, count_inc, count_dec;
  logic             in_range;

  assign up_tick   = en_up & ~up_q;
  assign dn_tick   = en_down & ~down_q;
  assign count_w   = {1'b0, count_reg};
  assign load_w    = {1'b0, load_val};
  assign count_inc = count_w + ONE_W;
  assign count_dec = count_w - ONE_W;
  assign in_range  = (count_w >= MIN_W) && (count_w <= MAX_W);

  always_comb begin
    count_next  = count_reg;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    if (load) begin
      if (load_w > MAX_W)
        count_next = MAX_N;
      else if (load_w < MIN_W)
        count_next = MIN_N;
      else
        count_next = load_val;
    end else if (!in_range) begin
      // Corrupted state recovers to the bottom of the range; any tick is dropped.
      count_next = MIN_N;
    end else if (up_tick && !dn_tick) begin
      if (count_w == MAX_W) begin
        count_next = MIN_N;
        carry_next = 1'b1;
      end else begin
        count_next = count_inc[WIDTH-1:0];
      end
    end else if (dn_tick && !up_tick) begin
      if (count_w == MIN_W) begin
        count_next  = MAX_N;
        borrow_next = 1'b1;
      end else begin
        count_next = count_dec[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= RESET_N;
      carry_reg  <= 1'b0;
      borrow_reg <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      count_reg  <= count_next;
      carry_reg  <= carry_next;
      borrow_reg <= borrow_next;
      up_q       <= en_up;
      down_q     <= en_down;
    end
  end

  assign count  = count_reg;
  assign carry  = carry_reg;
  assign borrow = borrow_reg;

`ifdef BCD_OUT_EN
  generate
    if (MAX_VAL > 99) begin : g_bcd_range_check
      $error("contador_ad_param: BCD_OUT_EN requires MAX_VAL <= 99");
    end
  endgenerate

  function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
    logic [31:0] v32;
    logic [31:0] tens;
    logic [31:0] units;
    v32   = 32'(v);
    tens  = v32 / 32'd10;
    units = v32 % 32'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  logic [7:0] bcd_reg;

  // Converted from count_next so the BCD copy lands on the same edge as count.
  always_ff @(posedge clk) begin
    if (reset)
      bcd_reg <= to_bcd(RESET_N);
    else
      bcd_reg <= to_bcd(count_next);
  end

  assign count_bcd = bcd_reg;
`endif

endmodule

// File: tb/tb_contador_ad_param.sv
// Scoreboard bench for contador_ad_param; the BCD scenario runs when BCD_OUT_EN is defined.
module tb_contador_ad_param;

`ifdef BCD_OUT_EN
  localparam int W = 7, MINV = 0, MAXV = 59, RSTV = 0;
`else
  localparam int W = 3, MINV = 1, MAXV = 7, RSTV = 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en_up = 1'b0;
  logic         en_down = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         carry, borrow;
`ifdef BCD_OUT_EN
  logic [7:0]   count_bcd;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [W-1:0] cnt;
    logic         c;
    logic         b;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  always #5 clk = ~clk;

  contador_ad_param #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV)) dut (
    .clk(clk), .reset(reset), .en_up(en_up), .en_down(en_down),
    .load(load), .load_val(load_val), .count(count), .carry(carry), .borrow(borrow)
`ifdef BCD_OUT_EN
    , .count_bcd(count_bcd)
`endif
  );

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic apply(input logic rst, input logic up, input logic dn,
                       input logic ld, input logic [W-1:0] lv);
    reset = rst; en_up = up; en_down = dn; load = ld; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int cnt, input logic c, input logic b);
    exp_t x;
    x.cnt = W'(cnt); x.c = c; x.b = b;
    sb_q.push_back(x);
  endtask

`ifndef BCD_OUT_EN
  task automatic test_reset;
    apply(1, 0, 0, 0, '0);
    apply(1, 0, 0, 0, '0);
    push(1, 0, 0);
    e = sb_q.pop_front();
    tests_run++;
    if ({count, carry, borrow} !== {e.cnt, e.c, e.b}) begin
      tests_failed++;
      $display("FAIL reset: got count=%0d carry=%b borrow=%b, want count=%0d carry=%b borrow=%b",
               count, carry, borrow, e.cnt, e.c, e.b);
    end
    // Held en_up gives exactly one increment.
    for (int i = 0; i < 11; i++) begin
      push(2, 0, 0);
      apply(0, (i < 10), 0, 0, '0);
      e = sb_q.pop_front();
      tests_run++;
      if ({count, carry, borrow} !== {e.cnt, e.c, e.b}) begin
        tests_failed++;
        $display("FAIL held_up[%0d]: got count=%0d c=%b b=%b, want count=%0d c=%b b=%b",
                 i, count, carry, borrow, e.cnt, e.c, e.b);
      end
    end
  endtask

  task automatic test_up_wrap;
    apply(1, 0, 0, 0, '0);
    for (int i = 1; i <= 14; i++) begin
      int p;
      p = (i + 1) / 2;
      if (p == 7) push(1, (i % 2 == 1), 0);
      else        push(p + 1, 0, 0);
      apply(0, (i % 2 == 1), 0, 0, '0);
      e = sb_q.pop_front();
      tests_run++;
      if ({count, carry, borrow} !== {e.cnt, e.c, e.b}) begin
        tests_failed++;
        $display("FAIL up_wrap[%0d]: got count=%0d c=%b b=%b, want count=%0d c=%b b=%b",
                 i, count, carry, borrow, e.cnt, e.c, e.b);
      end
    end
  endtask

  task automatic test_down_wrap;
    logic dn_tab[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int   cnt_tab[4] = '{7, 7, 6, 6};
    logic b_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    apply(1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      push(cnt_tab[i], 0, b_tab[i]);
      apply(0, 0, dn_tab[i], 0, '0);
      e = sb_q.pop_front();
      tests_run++;
      if ({count, carry, borrow} !== {e.cnt, e.c, e.b}) begin
        tests_failed++;
        $display("FAIL down_wrap[%0d]: got count=%0d c=%b b=%b, want count=%0d c=%b b=%b",
                 i, count, carry, borrow, e.cnt, e.c, e.b);
      end
    end
  endtask

  task automatic test_load;
    // Rows: up, load, load_val, expected count.
    logic           up_tab[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic           ld_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0]   lv_tab[5] = '{3'd0, 3'd5, 3'd0, 3'd7, 3'd0};
    int             cnt_tab[5] = '{1, 5, 5, 7, 7};
    for (int i = 0; i < 5; i++) begin
      push(cnt_tab[i], 0, 0);
      apply(0, up_tab[i], 0, ld_tab[i], lv_tab[i]);
      e = sb_q.pop_front();
      tests_run++;
      if ({count, carry, borrow} !== {e.cnt, e.c, e.b}) begin
        tests_failed++;
        $display("FAIL load[%0d]: got count=%0d c=%b b=%b, want count=%0d c=%b b=%b",
                 i, count, carry, borrow, e.cnt, e.c, e.b);
      end
    end
  endtask

  task automatic test_back_to_back;
    // Rows: reset, up, down, load, expected count.
    logic rst_tab[10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic up_tab[10]  = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 1};
    logic dn_tab[10]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic ld_tab[10]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int   cnt_tab[10] = '{4, 4, 4, 5, 1, 1, 1, 1, 1, 2};
    for (int i = 0; i < 10; i++) begin
      push(cnt_tab[i], 0, 0);
      apply(rst_tab[i], up_tab[i], dn_tab[i], ld_tab[i], 3'd4);
      e = sb_q.pop_front();
      tests_run++;
      if ({count, carry, borrow} !== {e.cnt, e.c, e.b}) begin
        tests_failed++;
        $display("FAIL same_cycle_reset[%0d]: got count=%0d c=%b b=%b, want count=%0d c=%b b=%b",
                 i, count, carry, borrow, e.cnt, e.c, e.b);
      end
    end
  endtask
`else
  task automatic test_bcd;
    logic           rst_tab[4] = '{1, 0, 0, 0};
    logic           up_tab[4]  = '{0, 0, 1, 0};
    logic           ld_tab[4]  = '{0, 1, 0, 0};
    int             cnt_tab[4] = '{0, 59, 0, 0};
    logic           c_tab[4]   = '{0, 0, 1, 0};
    logic [7:0]     bcd_tab[4] = '{8'h00, 8'h59, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      push(cnt_tab[i], c_tab[i], 0);
      apply(rst_tab[i], up_tab[i], 0, ld_tab[i], 7'd59);
      e = sb_q.pop_front();
      tests_run++;
      if ({count, carry, borrow, count_bcd} !== {e.cnt, e.c, e.b, bcd_tab[i]}) begin
        tests_failed++;
        $display("FAIL bcd[%0d]: got count=%0d c=%b b=%b bcd=%h, want count=%0d c=%b b=%b bcd=%h",
                 i, count, carry, borrow, count_bcd, e.cnt, e.c, e.b, bcd_tab[i]);
      end
    end
  endtask
`endif

  initial begin
`ifndef BCD_OUT_EN
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_back_to_back();
`else
    test_bcd();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
